multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Main sequencing FSM of the multicycle CPU. Decodes the 6-bit opcode held in the instruction register and steps each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath enable and mux select, including ExtSel for the immediate extender and the ALU B-operand mux.
- Sits upstream of the extender, register file, ALU and data memory. Consumes zero/sign flags from the ALU.

Parameters:
- STATE_W, 3, width of state register and o_state debug port
- OP_W, 6, opcode width

Ports:
- i_clk  input  1  system clock; all state changes on rising edge
- i_rst  input  1  synchronous active-high reset
- i_opcode  input  6  IR[31:26]; stable from end of IF until next IF
- i_zero  input  1  ALU result == 0
- i_sign  input  1  ALU result bit 31 (reserved; decoded only by bltz extension)
- o_PCWre  output  1  PC write enable
- o_IRWre  output  1  instruction register write enable
- o_InsMemRW  output  1  instruction memory read enable
- o_mRD  output  1  data memory read
- o_mWR  output  1  data memory write
- o_RegWre  output  1  register file write enable
- o_RegDst  output  2  write reg select: 00=$31, 01=rt, 10=rd
- o_WrRegDSrc  output  1  0=PC+4 (jal), 1=ALU/memory result
- o_DBDataSrc  output  1  0=ALU result, 1=memory data
- o_ALUSrcA  output  1  1=shamt (extender output), 0=rs
- o_ALUSrcB  output  1  1=extender output, 0=rt
- o_PCSrc  output  2  00=PC+4, 01=PC+4+(imm<<2), 10=rs, 11=jump target
- o_ALUOp  output  3  ALU function code
- o_ExtSel  output  2  00=shamt zero-ext, 01=imm zero-ext, 10=imm sign-ext
- o_state  output  3  current state (debug)

Behaviour:
- States: IF=000, ID=001, EXE_AL=110, EXE_BR=101, EXE_LS=010, MEM=011, WB_AL=111, WB_LD=100.
- Transitions out of IF, EXE and WB:
  - IF -> ID always.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for lw; MEM -> IF for sw.
  - WB_LD -> IF.
- Transitions out of ID:
  - j, jal, jr, halt -> IF.
  - beq, bne -> EXE_BR.
  - lw, sw -> EXE_LS.
  - add, sub, addiu, and, andi, ori, sll, slti -> EXE_AL.
  - Unknown opcode -> IF, treated as nop with PCWre=1.
- Instruction latency: jump 2 cycles, branch 3, ALU 4, sw 4, lw 5.
- Per-state enables:
  - IF: InsMemRW=1, IRWre=1.
  - PCWre=1 only in the final state of each instruction: ID for jumps and nops, EXE_BR, MEM for sw, WB_AL, WB_LD.
  - halt: PCWre=0 in ID. The FSM re-fetches the same halt forever; only reset exits.
- Branches: PCSrc=01 when (beq and i_zero) or (bne and !i_zero), else 00. Sampled in EXE_BR only.
- jal: RegWre=1, RegDst=00, WrRegDSrc=0 in ID. jr: PCSrc=10. j, jal: PCSrc=11.
- RegWre is asserted only in ID (jal), WB_AL and WB_LD. mWR only in MEM for sw. mRD only in MEM for lw.
- Decode is combinational: ExtSel, ALUSrcA/B, ALUOp, RegDst, DBDataSrc are pure functions of i_opcode. They are valid in every state.
- ExtSel: sll=00; andi, ori=01; all others=10.
- Outputs are Moore/Mealy combinational from state and opcode. The state register is the only storage.
- Reset:
  - On an i_rst edge the state becomes IF.
  - While i_rst=1, all write enables (PCWre, IRWre, RegWre, mWR) are forced to 0 the same cycle.
  - Reset asserted during MEM of sw suppresses the write.
  - Other outputs follow the IF decode.

Decomposition:
- Package cpu_defs holds:
  - state encodings;
  - opcode constants: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, sll 011000, slti 011100, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111;
  - ALUOp codes: ADD 000, SUB 001, SLL 010, OR 011, AND 100, SLT 110;
  - ExtSel codes.
- One sub-module, control_decode: combinational opcode -> select/ALUOp/ExtSel. The FSM and write-enable gating stay in the top.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with opcode=sw in MEM -> o_state=000, mWR=0 and PCWre=0 throughout. First cycle after release: IRWre=1.
- addiu (000010): state sequence 000,001,110,111,000 -> ExtSel=10, ALUSrcB=1, ALUOp=000, RegDst=01. RegWre=1 and PCWre=1 only in WB_AL.
- ori (010010) then sll (011000): ExtSel=01, then ExtSel=00 with ALUSrcA=1 and ALUOp=010.
- beq with i_zero=1, then with i_zero=0 -> PCSrc=01 vs 00 in EXE_BR. PCWre=1 in both. 3-cycle latency.
- lw (110001): 5 states ending 011,100 -> mRD=1 in MEM, DBDataSrc=1 and RegWre=1 in WB_LD. sw: mWR=1 in MEM, then IF.
- jal (111010): IF,ID only -> RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11 in ID. halt (111111): PCWre never asserts over 10 cycles.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALU function codes and the select codes driven by the control unit.
package cpu_defs;

   localparam int unsigned STATE_BITS = 3;
   localparam int unsigned OP_BITS    = 6;
   localparam int unsigned ALUOP_BITS = 3;
   localparam int unsigned SEL_BITS   = 2;

   typedef enum logic [STATE_BITS-1:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [OP_BITS-1:0] OP_ADD   = 6'b000000;
   localparam logic [OP_BITS-1:0] OP_SUB   = 6'b000001;
   localparam logic [OP_BITS-1:0] OP_ADDIU = 6'b000010;
   localparam logic [OP_BITS-1:0] OP_AND   = 6'b010000;
   localparam logic [OP_BITS-1:0] OP_ANDI  = 6'b010001;
   localparam logic [OP_BITS-1:0] OP_ORI   = 6'b010010;
   localparam logic [OP_BITS-1:0] OP_SLL   = 6'b011000;
   localparam logic [OP_BITS-1:0] OP_SLTI  = 6'b011100;
   localparam logic [OP_BITS-1:0] OP_SW    = 6'b110000;
   localparam logic [OP_BITS-1:0] OP_LW    = 6'b110001;
   localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OP_BITS-1:0] OP_BNE   = 6'b110101;
   localparam logic [OP_BITS-1:0] OP_J     = 6'b111000;
   localparam logic [OP_BITS-1:0] OP_JR    = 6'b111001;
   localparam logic [OP_BITS-1:0] OP_JAL   = 6'b111010;
   localparam logic [OP_BITS-1:0] OP_HALT  = 6'b111111;

   localparam logic [ALUOP_BITS-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUOP_BITS-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUOP_BITS-1:0] ALU_SLL = 3'b010;
   localparam logic [ALUOP_BITS-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUOP_BITS-1:0] ALU_AND = 3'b100;
   localparam logic [ALUOP_BITS-1:0] ALU_SLT = 3'b110;

   localparam logic [SEL_BITS-1:0] EXT_SHAMT = 2'b00;
   localparam logic [SEL_BITS-1:0] EXT_ZERO  = 2'b01;
   localparam logic [SEL_BITS-1:0] EXT_SIGN  = 2'b10;

   localparam logic [SEL_BITS-1:0] DST_R31 = 2'b00;
   localparam logic [SEL_BITS-1:0] DST_RT  = 2'b01;
   localparam logic [SEL_BITS-1:0] DST_RD  = 2'b10;

   localparam logic [SEL_BITS-1:0] PC_NEXT   = 2'b00;
   localparam logic [SEL_BITS-1:0] PC_BRANCH = 2'b01;
   localparam logic [SEL_BITS-1:0] PC_REG    = 2'b10;
   localparam logic [SEL_BITS-1:0] PC_JUMP   = 2'b11;

   // Instruction classes that need more than the IF/ID pair.
   function automatic logic is_alu(input logic [OP_BITS-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDIU, OP_AND,
         OP_ANDI, OP_ORI, OP_SLL, OP_SLTI: is_alu = 1'b1;
         default:                          is_alu = 1'b0;
      endcase
   endfunction

   function automatic logic is_branch(input logic [OP_BITS-1:0] op);
      is_branch = (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic is_mem(input logic [OP_BITS-1:0] op);
      is_mem = (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/control_decode.sv
// Opcode-only decode: datapath mux selects, ALU function and extender mode.
// Independent of FSM state, so these are valid in every cycle.
module control_decode
   import cpu_defs::*;
(
   input  logic [OP_BITS-1:0]    opcode,
   output logic                  alu_src_a,
   output logic                  alu_src_b,
   output logic [ALUOP_BITS-1:0] alu_op,
   output logic [SEL_BITS-1:0]   ext_sel,
   output logic [SEL_BITS-1:0]   reg_dst,
   output logic                  db_data_src,
   output logic                  wr_reg_d_src
);

   always_comb begin
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      ext_sel      = EXT_SIGN;
      reg_dst      = DST_RT;
      db_data_src  = 1'b0;
      wr_reg_d_src = 1'b1;
      case (opcode)
         OP_ADD:   reg_dst = DST_RD;
         OP_SUB: begin
            alu_op  = ALU_SUB;
            reg_dst = DST_RD;
         end
         OP_ADDIU: alu_src_b = 1'b1;
         OP_AND: begin
            alu_op  = ALU_AND;
            reg_dst = DST_RD;
         end
         OP_ANDI: begin
            alu_op    = ALU_AND;
            alu_src_b = 1'b1;
            ext_sel   = EXT_ZERO;
         end
         OP_ORI: begin
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
            ext_sel   = EXT_ZERO;
         end
         // Shift amount comes through the extender onto the A operand.
         OP_SLL: begin
            alu_op    = ALU_SLL;
            alu_src_a = 1'b1;
            ext_sel   = EXT_SHAMT;
            reg_dst   = DST_RD;
         end
         OP_SLTI: begin
            alu_op    = ALU_SLT;
            alu_src_b = 1'b1;
         end
         OP_SW:    alu_src_b = 1'b1;
         OP_LW: begin
            alu_src_b   = 1'b1;
            db_data_src = 1'b1;
         end
         OP_BEQ, OP_BNE: alu_op = ALU_SUB;
         OP_JAL: begin
            reg_dst      = DST_R31;
            wr_reg_d_src = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM of the multicycle CPU: steps each instruction through
// IF/ID/EXE/MEM/WB and drives every datapath enable and select.
module multicycle_control_unit
   import cpu_defs::*;
#(
   parameter int unsigned STATE_W = 3,
   parameter int unsigned OP_W    = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [OP_W-1:0]    i_opcode,
   input  logic               i_zero,
   input  logic               i_sign,
   output logic               o_PCWre,
   output logic               o_IRWre,
   output logic               o_InsMemRW,
   output logic               o_mRD,
   output logic               o_mWR,
   output logic               o_RegWre,
   output logic [1:0]         o_RegDst,
   output logic               o_WrRegDSrc,
   output logic               o_DBDataSrc,
   output logic               o_ALUSrcA,
   output logic               o_ALUSrcB,
   output logic [1:0]         o_PCSrc,
   output logic [2:0]         o_ALUOp,
   output logic [1:0]         o_ExtSel,
   output logic [STATE_W-1:0] o_state
);

   state_t               state;
   state_t               next_state;
   state_t               cur_state;
   logic [OP_BITS-1:0]   op;
   logic                 multi_cycle;
   logic                 pc_wre;
   logic                 ir_wre;
   logic                 ins_mem_rw;
   logic                 m_rd;
   logic                 m_wr;
   logic                 reg_wre;
   logic [SEL_BITS-1:0]  pc_src;
   logic                 unused_sign;

   assign op          = OP_BITS'(i_opcode);
   assign multi_cycle = is_alu(op) || is_branch(op) || is_mem(op);
   assign unused_sign = i_sign;

   // While reset is held, outputs behave as if already in IF.
   assign cur_state = i_rst ? S_IF : state;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IF;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_IF;
      case (state)
         S_IF: next_state = S_ID;
         S_ID: begin
            if (is_branch(op))   next_state = S_EXE_BR;
            else if (is_mem(op)) next_state = S_EXE_LS;
            else if (is_alu(op)) next_state = S_EXE_AL;
            else                 next_state = S_IF;
         end
         S_EXE_AL: next_state = S_WB_AL;
         S_EXE_BR: next_state = S_IF;
         S_EXE_LS: next_state = S_MEM;
         S_MEM:    next_state = (op == OP_LW) ? S_WB_LD : S_IF;
         S_WB_AL:  next_state = S_IF;
         S_WB_LD:  next_state = S_IF;
         default:  next_state = S_IF;
      endcase
   end

   // PCWre fires in the last state of each instruction; halt never retires.
   always_comb begin
      pc_wre     = 1'b0;
      ir_wre     = 1'b0;
      ins_mem_rw = 1'b0;
      m_rd       = 1'b0;
      m_wr       = 1'b0;
      reg_wre    = 1'b0;
      pc_src     = PC_NEXT;
      case (cur_state)
         S_IF: begin
            ins_mem_rw = 1'b1;
            ir_wre     = 1'b1;
         end
         S_ID: begin
            pc_wre  = !multi_cycle && (op != OP_HALT);
            reg_wre = (op == OP_JAL);
            if ((op == OP_J) || (op == OP_JAL)) pc_src = PC_JUMP;
            else if (op == OP_JR)               pc_src = PC_REG;
         end
         S_EXE_BR: begin
            pc_wre = 1'b1;
            if (((op == OP_BEQ) && i_zero) || ((op == OP_BNE) && !i_zero))
               pc_src = PC_BRANCH;
         end
         S_MEM: begin
            m_wr   = (op == OP_SW);
            pc_wre = (op == OP_SW);
            m_rd   = (op == OP_LW);
         end
         S_WB_AL, S_WB_LD: begin
            pc_wre  = 1'b1;
            reg_wre = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_PCWre    = pc_wre  & ~i_rst;
   assign o_IRWre    = ir_wre  & ~i_rst;
   assign o_RegWre   = reg_wre & ~i_rst;
   assign o_mWR      = m_wr    & ~i_rst;
   assign o_InsMemRW = ins_mem_rw;
   assign o_mRD      = m_rd;
   assign o_PCSrc    = pc_src;
   assign o_state    = STATE_W'(cur_state);

   control_decode u_decode (
      .opcode       (op),
      .alu_src_a    (o_ALUSrcA),
      .alu_src_b    (o_ALUSrcB),
      .alu_op       (o_ALUOp),
      .ext_sel      (o_ExtSel),
      .reg_dst      (o_RegDst),
      .db_data_src  (o_DBDataSrc),
      .wr_reg_d_src (o_WrRegDSrc)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver pushes one expected
// output vector per cycle from an instruction-level model, the monitor pops and compares.
module tb_multicycle_control_unit;
   import cpu_defs::*;

   typedef struct packed {
      logic [2:0] state;
      logic       pcwre;
      logic       irwre;
      logic       insmem;
      logic       mrd;
      logic       mwr;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       dbsrc;
      logic       srca;
      logic       srcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic [1:0] extsel;
   } obs_t;

   logic       clk;
   logic       i_rst;
   logic [5:0] i_opcode;
   logic       i_zero;
   logic       i_sign;
   logic       o_PCWre, o_IRWre, o_InsMemRW, o_mRD, o_mWR, o_RegWre;
   logic [1:0] o_RegDst;
   logic       o_WrRegDSrc, o_DBDataSrc, o_ALUSrcA, o_ALUSrcB;
   logic [1:0] o_PCSrc;
   logic [2:0] o_ALUOp;
   logic [1:0] o_ExtSel;
   logic [2:0] o_state;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   multicycle_control_unit #(.STATE_W(3), .OP_W(6)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_opcode    (i_opcode),
      .i_zero      (i_zero),
      .i_sign      (i_sign),
      .o_PCWre     (o_PCWre),
      .o_IRWre     (o_IRWre),
      .o_InsMemRW  (o_InsMemRW),
      .o_mRD       (o_mRD),
      .o_mWR       (o_mWR),
      .o_RegWre    (o_RegWre),
      .o_RegDst    (o_RegDst),
      .o_WrRegDSrc (o_WrRegDSrc),
      .o_DBDataSrc (o_DBDataSrc),
      .o_ALUSrcA   (o_ALUSrcA),
      .o_ALUSrcB   (o_ALUSrcB),
      .o_PCSrc     (o_PCSrc),
      .o_ALUOp     (o_ALUOp),
      .o_ExtSel    (o_ExtSel),
      .o_state     (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic alu_class(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI};
   endfunction

   // Cycles per instruction: jump/nop/halt 2, branch 3, ALU 4, sw 4, lw 5.
   function automatic int seq_len(input logic [5:0] op);
      if (op == OP_LW) return 5;
      if (alu_class(op) || op == OP_SW) return 4;
      if (op == OP_BEQ || op == OP_BNE) return 3;
      return 2;
   endfunction

   function automatic logic [2:0] seq_state(input logic [5:0] op, input int idx);
      case (idx)
         0: return 3'b000;
         1: return 3'b001;
         2: return alu_class(op) ? 3'b110 : ((op == OP_BEQ || op == OP_BNE) ? 3'b101 : 3'b010);
         3: return alu_class(op) ? 3'b111 : 3'b011;
         default: return 3'b100;
      endcase
   endfunction

   function automatic obs_t model(input logic [5:0] op, input int idx_in, input logic z, input logic r);
      obs_t e;
      int   idx;
      logic last;
      idx  = r ? 0 : idx_in;
      last = (idx == seq_len(op) - 1);
      e.state  = seq_state(op, idx);
      e.pcwre  = !r && last && (op != OP_HALT);
      e.irwre  = !r && (idx == 0);
      e.insmem = (idx == 0);
      e.mrd    = (op == OP_LW) && (idx == 3);
      e.mwr    = !r && (op == OP_SW) && last;
      e.regwre = !r && ((last && (alu_class(op) || op == OP_LW)) || (op == OP_JAL && idx == 1));
      e.pcsrc  = 2'b00;
      if (idx == 1 && (op == OP_J || op == OP_JAL)) e.pcsrc = 2'b11;
      if (idx == 1 && op == OP_JR)                  e.pcsrc = 2'b10;
      if (idx == 2 && ((op == OP_BEQ && z) || (op == OP_BNE && !z))) e.pcsrc = 2'b01;
      e.extsel = (op == OP_SLL) ? 2'b00 : ((op == OP_ANDI || op == OP_ORI) ? 2'b01 : 2'b10);
      e.srca   = (op == OP_SLL);
      e.srcb   = op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
      e.dbsrc  = (op == OP_LW);
      e.wrsrc  = (op != OP_JAL);
      e.regdst = (op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL}) ? 2'b10 : ((op == OP_JAL) ? 2'b00 : 2'b01);
      case (op)
         OP_SUB, OP_BEQ, OP_BNE: e.aluop = 3'b001;
         OP_AND, OP_ANDI:        e.aluop = 3'b100;
         OP_ORI:                 e.aluop = 3'b011;
         OP_SLL:                 e.aluop = 3'b010;
         OP_SLTI:                e.aluop = 3'b110;
         default:                e.aluop = 3'b000;
      endcase
      return e;
   endfunction

   task automatic step(input logic [5:0] op, input int idx, input logic z, input logic r);
      @(posedge clk);
      #1;
      i_opcode = op;
      i_zero   = z;
      i_sign   = 1'($urandom_range(0, 1));
      i_rst    = r;
      exp_q.push_back(model(op, idx, z, r));
      tag_q.push_back($sformatf("op%b_c%0d%s", op, idx, r ? "_rst" : ""));
   endtask

   // zmode 0/1 fixes i_zero, 2 randomises it; rst_at >= 0 aborts with a 2-cycle reset.
   task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_at);
      logic z;
      for (int i = 0; i < seq_len(op); i++) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         if (i == rst_at) begin
            step(op, i, z, 1'b1);
            step(op, 0, z, 1'b1);
            return;
         end
         step(op, i, z, 1'b0);
      end
   endtask

   always @(negedge clk) begin
      obs_t  got;
      obs_t  want;
      string tag;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         got = '{state: o_state, pcwre: o_PCWre, irwre: o_IRWre, insmem: o_InsMemRW,
                 mrd: o_mRD, mwr: o_mWR, regwre: o_RegWre, regdst: o_RegDst,
                 wrsrc: o_WrRegDSrc, dbsrc: o_DBDataSrc, srca: o_ALUSrcA, srcb: o_ALUSrcB,
                 pcsrc: o_PCSrc, aluop: o_ALUOp, extsel: o_ExtSel};
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (state/pcwre/irwre/insmem/mrd/mwr/regwre/regdst/wrsrc/dbsrc/srca/srcb/pcsrc/aluop/extsel)",
                     tag, got, want);
         end
      end
   end

   logic [5:0] ops [16] = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI,
                            OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL, OP_HALT};

   initial begin
      logic [5:0] op;
      int         ra;
      i_rst    = 1'b1;
      i_opcode = OP_SW;
      i_zero   = 1'b0;
      i_sign   = 1'b0;
      step(OP_SW, 0, 1'b0, 1'b1);
      step(OP_SW, 0, 1'b0, 1'b1);

      run_instr(OP_ADDIU, 2, -1);
      run_instr(OP_ORI,   2, -1);
      run_instr(OP_SLL,   2, -1);
      run_instr(OP_BEQ,   1, -1);
      run_instr(OP_BEQ,   0, -1);
      run_instr(OP_BNE,   0, -1);
      run_instr(OP_BNE,   1, -1);
      run_instr(OP_LW,    2, -1);
      run_instr(OP_SW,    2, -1);
      run_instr(OP_JAL,   2, -1);
      run_instr(OP_J,     2, -1);
      run_instr(OP_JR,    2, -1);
      for (int k = 0; k < 5; k++) run_instr(OP_HALT, 2, -1);
      run_instr(6'b101010, 2, -1);
      run_instr(OP_SW, 2, 3);
      run_instr(OP_LW, 2, 4);
      run_instr(OP_ADD, 2, -1);

      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
         else                           op = ops[$urandom_range(0, 15)];
         ra = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, seq_len(op) - 1)) : -1;
         run_instr(op, 2, ra);
      end

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
